// File: rtl/load_port_arbiter.sv
// -----------------------------------------------------------------------------
// load_port_arbiter
//
// Shares the single load/execute port of tiny_processor between two
// requesters. A requester keeps the port until it drops its request, or,
// when the other requester is waiting, until it has completed QUANTUM
// executions and is sitting in idle mode. Every grant is followed by a
// TURN_CYCLES turnaround with nothing driven onto the port.
//
// Parameters
//   QUANTUM      executions a requester may finish before it can be preempted
//   TURN_CYCLES  idle turnaround cycles between grants (1..15)
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   req[1:0]     per-requester level request
//   mosi_in[1:0] per-requester serial load data
//   mode_in0/1   per-requester mode (00 idle, 01 imem, 10 dmem, 11 exec)
//   done_in      execution-complete pulse from tiny_processor
//   gnt[1:0]     registered one-hot grant, or zero
//   done_out     done_in routed to the granted requester
//   mosi_out     serial load data to tiny_processor
//   mode_out     mode to tiny_processor
//   preempted    one-cycle pulse when a grant is revoked by preemption
// -----------------------------------------------------------------------------
module load_port_arbiter #(
    parameter int QUANTUM     = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mosi_in,
    input  logic [1:0] mode_in0,
    input  logic [1:0] mode_in1,
    input  logic       done_in,
    output logic [1:0] gnt,
    output logic [1:0] done_out,
    output logic       mosi_out,
    output logic [1:0] mode_out,
    output logic [1:0] preempted
);

    // A zero quantum still needs a one-bit counter to compare against.
    localparam int CNT_W = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] QUANTUM_V = CNT_W'(QUANTUM);
    localparam logic [3:0]       TURN_LAST = 4'(TURN_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    localparam logic [1:0] TURN = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       preempted_nxt;
    logic             last_served;
    logic [CNT_W-1:0] exec_cnt;
    logic [3:0]       turn_cnt;

    logic             owner;       // index of the requester holding the grant
    logic             owner_req;
    logic             other_req;
    logic [1:0]       owner_mode;
    logic             in_grant;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_nxt     = state;
        preempted_nxt = 2'b00;
        owner         = (state == GNT1);
        owner_req     = owner ? req[1] : req[0];
        other_req     = owner ? req[0] : req[1];
        owner_mode    = owner ? mode_in1 : mode_in0;
        in_grant      = (state == GNT0) || (state == GNT1);

        case (state)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (req == 2'b11)
                    state_nxt = last_served ? GNT0 : GNT1;
                else if (req[0])
                    state_nxt = GNT0;
                else if (req[1])
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!owner_req) begin
                    state_nxt = TURN;
                end else if (other_req && (exec_cnt == QUANTUM_V) &&
                             (owner_mode == 2'b00)) begin
                    // Only an owner in idle mode is preempted, so a load or
                    // execute already under way always runs to completion.
                    state_nxt     = TURN;
                    preempted_nxt = owner ? 2'b10 : 2'b01;
                end
            end
            default: begin  // TURN
                if (turn_cnt == TURN_LAST)
                    state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            preempted   <= 2'b00;
            exec_cnt    <= '0;
            turn_cnt    <= 4'd0;
            last_served <= 1'b1;
        end else begin
            state     <= state_nxt;
            gnt       <= {state_nxt == GNT1, state_nxt == GNT0};
            preempted <= preempted_nxt;

            if (state == IDLE && state_nxt != IDLE) begin
                last_served <= (state_nxt == GNT1);
                exec_cnt    <= '0;
            end else if (in_grant && done_in && exec_cnt != QUANTUM_V) begin
                exec_cnt <= exec_cnt + CNT_W'(1);
            end

            if (state == TURN && state_nxt == TURN)
                turn_cnt <= turn_cnt + 4'd1;
            else
                turn_cnt <= 4'd0;
        end
    end

    // The port mux is steered by the registered grant, so IDLE, TURN and
    // reset all present an idle port.
    always_comb begin
        mosi_out = 1'b0;
        mode_out = 2'b00;
        if (gnt[0]) begin
            mosi_out = mosi_in[0];
            mode_out = mode_in0;
        end else if (gnt[1]) begin
            mosi_out = mosi_in[1];
            mode_out = mode_in1;
        end
    end

    assign done_out = {done_in & gnt[1], done_in & gnt[0]};

endmodule

// File: tb/tb_load_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_load_port_arbiter
//
// Directed bench for load_port_arbiter. A vector table walks the default
// configuration through tie-break, quantum hold while busy, preemption,
// turnaround masking and voluntary release; hand sequences cover reset
// mid-grant, a lone persistent requester and a zero quantum.
// Inputs change just after the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_load_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, mosi_in, mode_in0, mode_in1;
    logic       done_in;
    logic [1:0] gnt, done_out, mode_out, preempted;
    logic       mosi_out;

    // Second instance: QUANTUM = 0, TURN_CYCLES = 1.
    logic [1:0] req_z;
    logic [1:0] gnt_z, done_out_z, mode_out_z, preempted_z;
    logic       mosi_out_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_port_arbiter #(.QUANTUM(4), .TURN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mosi_in(mosi_in),
        .mode_in0(mode_in0), .mode_in1(mode_in1), .done_in(done_in),
        .gnt(gnt), .done_out(done_out), .mosi_out(mosi_out),
        .mode_out(mode_out), .preempted(preempted)
    );

    load_port_arbiter #(.QUANTUM(0), .TURN_CYCLES(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .req(req_z), .mosi_in(2'b00),
        .mode_in0(2'b00), .mode_in1(2'b00), .done_in(1'b0),
        .gnt(gnt_z), .done_out(done_out_z), .mosi_out(mosi_out_z),
        .mode_out(mode_out_z), .preempted(preempted_z)
    );

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] mosi;
        logic [1:0] m0;
        logic [1:0] m1;
        logic       done;
        logic [1:0] e_gnt;
        logic [1:0] e_done;
        logic       e_mosi;
        logic [1:0] e_mode;
        logic [1:0] e_pre;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] mo,
                                input logic [1:0] m0, input logic [1:0] m1,
                                input logic d, input logic [1:0] eg,
                                input logic [1:0] ed, input logic em,
                                input logic [1:0] emd, input logic [1:0] ep);
        vec_t v;
        v.req = r; v.mosi = mo; v.m0 = m0; v.m1 = m1; v.done = d;
        v.e_gnt = eg; v.e_done = ed; v.e_mosi = em; v.e_mode = emd; v.e_pre = ep;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        //            req    mosi   m0     m1     dn    gnt    dout   mo    mode   pre
        vecs[0]  = mk(2'b11, 2'b10, 2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // IDLE, tie
        vecs[1]  = mk(2'b11, 2'b01, 2'b01, 2'b10, 1'b1, 2'b01, 2'b01, 1'b1, 2'b01, 2'b00); // GNT0, done 1
        vecs[2]  = mk(2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 2'b01, 2'b01, 1'b0, 2'b11, 2'b00); // done 2
        vecs[3]  = mk(2'b11, 2'b01, 2'b11, 2'b10, 1'b1, 2'b01, 2'b01, 1'b1, 2'b11, 2'b00); // done 3
        vecs[4]  = mk(2'b11, 2'b00, 2'b11, 2'b10, 1'b1, 2'b01, 2'b01, 1'b0, 2'b11, 2'b00); // done 4
        vecs[5]  = mk(2'b11, 2'b00, 2'b11, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 2'b11, 2'b00); // quantum, busy
        vecs[6]  = mk(2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00); // idle -> preempt
        vecs[7]  = mk(2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01); // TURN 0, pulse
        vecs[8]  = mk(2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // TURN 1
        vecs[9]  = mk(2'b11, 2'b11, 2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // IDLE, tie
        vecs[10] = mk(2'b11, 2'b10, 2'b00, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 2'b00); // GNT1
        vecs[11] = mk(2'b01, 2'b10, 2'b00, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 2'b00); // done + drop
        vecs[12] = mk(2'b01, 2'b11, 2'b01, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // TURN 0
        vecs[13] = mk(2'b01, 2'b11, 2'b01, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // TURN 1, done lost
        vecs[14] = mk(2'b01, 2'b01, 2'b01, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // IDLE
        vecs[15] = mk(2'b00, 2'b01, 2'b01, 2'b11, 1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 2'b00); // GNT0, drop
        vecs[16] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // TURN 0
        vecs[17] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // TURN 1
        vecs[18] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // IDLE
        vecs[19] = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00); // IDLE

        rst_n = 1'b0; req = 2'b00; mosi_in = 2'b11; mode_in0 = 2'b11;
        mode_in1 = 2'b11; done_in = 1'b1; req_z = 2'b00;
        #1;
        check("reset gnt",       8'(gnt),       8'h0);
        check("reset preempted", 8'(preempted), 8'h0);
        check("reset mosi_out",  8'(mosi_out),  8'h0);
        check("reset mode_out",  8'(mode_out),  8'h0);
        check("reset done_out",  8'(done_out),  8'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; mosi_in = 2'b00; mode_in0 = 2'b00; mode_in1 = 2'b00; done_in = 1'b0;

        // ---- vector table ----
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = vecs[i].req; mosi_in = vecs[i].mosi; mode_in0 = vecs[i].m0;
            mode_in1 = vecs[i].m1; done_in = vecs[i].done;
            #1;
            check($sformatf("v%0d gnt", i),       8'(gnt),       8'(vecs[i].e_gnt));
            check($sformatf("v%0d done_out", i),  8'(done_out),  8'(vecs[i].e_done));
            check($sformatf("v%0d mosi_out", i),  8'(mosi_out),  8'(vecs[i].e_mosi));
            check($sformatf("v%0d mode_out", i),  8'(mode_out),  8'(vecs[i].e_mode));
            check($sformatf("v%0d preempted", i), 8'(preempted), 8'(vecs[i].e_pre));
        end

        // ---- reset during a dmem load ----
        @(negedge clk);
        req = 2'b01; mode_in0 = 2'b10; mode_in1 = 2'b11; done_in = 1'b0;
        @(negedge clk);
        #1;
        check("rst pre gnt",      8'(gnt),      8'h1);
        check("rst pre mode_out", 8'(mode_out), 8'h2);
        #2;
        rst_n = 1'b0; done_in = 1'b1;
        #1;
        check("rst async gnt",      8'(gnt),      8'h0);
        check("rst async mode_out", 8'(mode_out), 8'h0);
        check("rst async done_out", 8'(done_out), 8'h0);
        @(negedge clk);
        rst_n = 1'b1; req = 2'b11; mode_in0 = 2'b01; done_in = 1'b0;
        #1;
        check("rst release idle gnt", 8'(gnt), 8'h0);
        @(negedge clk);
        #1;
        check("rst tie gnt",      8'(gnt),      8'h1);
        check("rst tie mode_out", 8'(mode_out), 8'h1);
        req = 2'b00; mode_in0 = 2'b00; mode_in1 = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        check("rst drain gnt", 8'(gnt), 8'h0);

        // ---- lone persistent requester 1 ----
        req = 2'b10;
        for (int i = 0; i < 101; i++) begin
            @(negedge clk);
            done_in = (i % 10 == 5);
            #1;
            if (i >= 1) begin
                check($sformatf("solo c%0d gnt", i),      8'(gnt),      8'h2);
                check($sformatf("solo c%0d done_out", i), 8'(done_out), done_in ? 8'h2 : 8'h0);
            end
            check($sformatf("solo c%0d preempted", i), 8'(preempted), 8'h0);
        end
        done_in = 1'b0; req = 2'b00;

        // ---- zero quantum: preempted on the first idle-mode cycle ----
        @(negedge clk);
        req_z = 2'b11;
        #1;
        check("q0 idle gnt", 8'(gnt_z), 8'h0);
        @(negedge clk); #1;
        check("q0 gnt0",      8'(gnt_z),       8'h1);
        check("q0 gnt0 pre",  8'(preempted_z), 8'h0);
        @(negedge clk); #1;
        check("q0 turn gnt",  8'(gnt_z),       8'h0);
        check("q0 turn pre",  8'(preempted_z), 8'h1);
        @(negedge clk); #1;
        check("q0 idle2 gnt", 8'(gnt_z),       8'h0);
        check("q0 idle2 pre", 8'(preempted_z), 8'h0);
        @(negedge clk); #1;
        check("q0 gnt1",      8'(gnt_z),       8'h2);
        @(negedge clk); #1;
        check("q0 turn2 pre", 8'(preempted_z), 8'h2);
        req_z = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_port_arbiter.md
LOAD_PORT_ARBITER -- requirements
Module: load_port_arbiter

Interface
REQ-001 The block SHALL have parameter QUANTUM, default 4: tiny_processor executions (done_in pulses) a requester may complete before it can be preempted.
REQ-002 The block SHALL have parameter TURN_CYCLES, default 2: idle turnaround cycles between grants, legal range 1..15.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req[1:0]  input  2  per-requester level request for the load/execute port.
REQ-006 mosi_in[1:0]  input  2  per-requester serial load data.
REQ-007 mode_in0, mode_in1  input  2 each  per-requester mode: 00 idle, 01 imem load, 10 dmem load, 11 execute.
REQ-008 done_in  input  1  execution-complete pulse from tiny_processor.
REQ-009 gnt[1:0]  output  2  registered one-hot grant, or zero.
REQ-010 done_out[1:0]  output  2  done_in routed to the granted requester.
REQ-011 mosi_out  output  1  serial load data to tiny_processor.
REQ-012 mode_out  output  2  mode to tiny_processor.
REQ-013 preempted[1:0]  output  2  one-cycle pulse when a requester's grant is revoked by preemption.

Function
REQ-014 State machine SHALL have exactly these states: IDLE, GNT0, GNT1, TURN.
REQ-015 IDLE: if any req bit is set, next state SHALL be GNTi for the winner; otherwise stay in IDLE.
REQ-016 Winner: sole requester if only one; if both request, the requester other than last_served.
REQ-017 On entry to GNTi, last_served SHALL become i and exec_cnt SHALL clear to 0.
REQ-018 gnt[i] SHALL be 1 exactly while state is GNTi (registered); first grant cycle is the cycle after req is sampled in IDLE.
REQ-019 In GNTi, mosi_out = mosi_in[i] and mode_out = mode_ini, combinationally; in IDLE and TURN, mosi_out = 0 and mode_out = 00.
REQ-020 done_out[i] = done_in AND (state == GNTi); done_in in IDLE or TURN SHALL be dropped.
REQ-021 In GNTi, each done_in cycle SHALL increment exec_cnt, saturating at QUANTUM; counter width SHALL be clog2(QUANTUM+1).
REQ-022 In GNTi with req[i] = 0: next state SHALL be TURN (voluntary release), regardless of mode_ini.
REQ-023 Preemption: in GNTi, if req[i] = 1, req[1-i] = 1, exec_cnt == QUANTUM and mode_ini == 00, next state SHALL be TURN and preempted[i] SHALL pulse high in the first TURN cycle.
REQ-024 No preemption SHALL occur while mode_ini != 00; a load or execute in progress always completes.
REQ-025 Otherwise GNTi SHALL hold.
REQ-026 TURN SHALL last exactly TURN_CYCLES cycles (turn_cnt counts 0..TURN_CYCLES-1), then go to IDLE.
REQ-027 Minimum gap from gnt falling to the next gnt rising SHALL be TURN_CYCLES+1 cycles.
REQ-028 done_in and the req[i] fall in the same GNTi cycle: done_out[i] SHALL pulse that cycle, and the release SHALL still occur.
REQ-029 With QUANTUM = 0, preemption SHALL be possible from the first idle-mode cycle of a grant.
REQ-030 A single persistent requester SHALL never be preempted; it keeps the grant indefinitely.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, gnt = 00, preempted = 00, exec_cnt = 0, turn_cnt = 0, and last_served = 1 (requester 0 wins the first tie).
REQ-032 While rst_n is low, outputs SHALL be mosi_out = 0, mode_out = 00, done_out = 00.
REQ-033 Reset asserted mid-grant SHALL drop gnt immediately, with no TURN period.
REQ-034 After reset releases, arbitration SHALL start on the first posedge.

Verification
REQ-035 Reset release, then req = 11 at cycle 0 -> gnt = 01 at cycle 1; mode_out follows mode_in0.
REQ-036 Requester 0 holds grant, drops req at cycle N -> gnt = 00 at N+1, mode_out = 00 for cycles N+1..N+2 (TURN_CYCLES = 2), IDLE at N+3, gnt = 10 at N+4 if req[1] set.
REQ-037 Both requesting, 4 done_in pulses to requester 0 with mode_in0 = 11 held -> no preemption; when mode_in0 returns to 00 -> preempted = 01 pulse, gnt = 10 after the turnaround.
REQ-038 done_in during TURN -> done_out = 00; done_in during GNT1 -> done_out = 10 in the same cycle.
REQ-039 rst_n pulled low mid-dmem-load (mode_out = 10) -> gnt = 00, mode_out = 00 immediately; after release with req = 11 -> requester 0 granted.
REQ-040 Only req[1] asserted for 100 cycles with 10 done_in pulses -> gnt stays 10, preempted stays 00.
